multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences the shared multi-cycle RV32I datapath: one memory, one ALU, IR/OldPC/A/B/ALUOut/Data regs.
//  Supports add,sub,and,or,slt,lw,addi,ori,slti,jalr,sw,beq,bne,jal,lui.
//  Per instruction it steps through FETCH/DECODE/execute/writeback states and drives every mux select and write strobe.
//  Stalls on a memory ready handshake.
// PARAMETERS
//  HALT_ON_ILLEGAL  1  1: unknown opcode -> ERROR (sticky); 0: treat as NOP, return to FETCH
// PORTS
//  clk         in   1  clock, rising edge
//  rst         in   1  reset, asynchronous, active-high
//  opcode      in   7  IR[6:0], valid from DECODE onward
//  func3       in   3  IR[14:12]
//  func7       in   7  IR[31:25]
//  zero        in   1  ALU zero flag (combinational, current cycle)
//  mem_ready   in   1  memory completes the current access this cycle
//  PCWrite     out  1  load PC from Result
//  AdrSrc      out  1  mem addr: 0=PC, 1=Result
//  IRWrite     out  1  load IR and OldPC
//  MemWrite    out  1  memory write strobe
//  RegWrite    out  1  register-file write strobe
//  ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
//  ALUSrcA     out  2  00=PC, 01=OldPC, 10=A
//  ALUSrcB     out  2  00=B, 01=ImmExt, 10=const 4
//  ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  ImmSrc      out  3  000 I, 001 S, 010 B, 011 J, 100 U
//  instr_done  out  1  1-cycle pulse on an instruction's final state
//  illegal     out  1  high while in ERROR
// BEHAVIOUR
//  Reset (async): state=FETCH.
//   While rst=1, PCWrite/IRWrite/MemWrite/RegWrite/instr_done/illegal are 0; other outputs show FETCH decode.
//  Outputs are combinational from state; unlisted outputs are 0. ALUControl=add unless stated. ImmSrc is set from opcode in every state after FETCH.
//  FETCH: AdrSrc=0, SrcA=00, SrcB=10, ResultSrc=10.
//   IRWrite=PCWrite=mem_ready. Hold state until mem_ready=1, then go to DECODE.
//  DECODE: SrcA=01, SrcB=01 (ALUOut<=branch/jal target).
//   Next state by opcode: 51->EXEC_R, 19->EXEC_I, 3/35->MEM_ADR, 99->BRANCH, 111->JAL, 103->JALR, 55->LUI.
//   Any other opcode -> ERROR (HALT_ON_ILLEGAL=1), else FETCH with instr_done=1.
//  EXEC_R: SrcA=10, SrcB=00. ALUControl by {func7,func3}: 0/000 add, 0x20/000 sub, 0/111 and, 0/110 or, 0/010 slt, other add. Next ALU_WB.
//  EXEC_I: SrcA=10, SrcB=01. func3: 000 add, 110 or, 010 slt, other add. Next ALU_WB.
//  ALU_WB: ResultSrc=00, RegWrite=1, instr_done=1. Next FETCH.
//  MEM_ADR: SrcA=10, SrcB=01. Next MEM_RD if opcode=3, else MEM_WR.
//  MEM_RD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then MEM_WB.
//  MEM_WB: ResultSrc=01, RegWrite=1, instr_done=1. Next FETCH.
//  MEM_WR: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. instr_done=mem_ready. On mem_ready go to FETCH.
//  BRANCH: SrcA=10, SrcB=00, sub, ResultSrc=00.
//   PCWrite=(func3=000 & zero)|(func3=001 & !zero); other func3 gives no write. instr_done=1. Next FETCH.
//  JAL: ResultSrc=00 with PCWrite=1 (PC<=target); SrcA=01, SrcB=10 (ALUOut<=OldPC+4). Next ALU_WB.
//  JALR: SrcA=10, SrcB=01 (ALUOut<=rs1+imm). Next JALR_PC.
//  JALR_PC: ResultSrc=00, PCWrite=1, SrcA=01, SrcB=10. Next ALU_WB.
//  LUI: ResultSrc=11, RegWrite=1, instr_done=1. Next FETCH.
//  ERROR: all strobes 0, illegal=1. Leaves only on reset.
//  Latency with zero-wait memory, in cycles: R/I-ALU 4, lw 5, sw 4, beq/bne 3, jal 4, jalr 5, lui 3. Each mem_ready=0 cycle adds 1.
//  Reset mid-instruction aborts it; no strobe fires after rst rises.
// TESTING
//  add x3,x1,x2 with mem_ready=1 -> states F,D,EXEC_R,ALU_WB; ALUControl=000, RegWrite only in cycle 4, instr_done in cycle 4.
//  lw with mem_ready low 2 cycles in MEM_RD -> 7 cycles total; AdrSrc=1 in MEM_RD; RegWrite=1 with ResultSrc=01 once.
//  beq zero=1 -> PCWrite=1 in BRANCH. bne zero=1 -> PCWrite=0. Both take 3 cycles with ALUControl=001.
//  jalr -> JALR, JALR_PC (PCWrite=1, ResultSrc=00), ALU_WB (RegWrite=1). 5 cycles.
//  opcode 7'h7F, HALT_ON_ILLEGAL=1 -> ERROR, illegal=1, no strobes for 20 cycles. Async rst -> FETCH, illegal=0.
//  rst pulsed during MEM_WR while mem_ready=0 -> MemWrite drops immediately; FETCH resumes after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the shared multi-cycle RV32I datapath: sequences fetch, decode,
// execute and writeback, and drives every mux select and write strobe.
module multicycle_controller #(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrc,
   output logic       instr_done,
   output logic       illegal
);

   localparam logic [6:0] OP_R    = 7'd51;
   localparam logic [6:0] OP_I    = 7'd19;
   localparam logic [6:0] OP_LW   = 7'd3;
   localparam logic [6:0] OP_SW   = 7'd35;
   localparam logic [6:0] OP_BR   = 7'd99;
   localparam logic [6:0] OP_JAL  = 7'd111;
   localparam logic [6:0] OP_JALR = 7'd103;
   localparam logic [6:0] OP_LUI  = 7'd55;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR, S_MEM_RD, S_MEM_WB,
      S_MEM_WR, S_BRANCH, S_JAL, S_JALR, S_JALR_PC, S_LUI, S_ERROR
   } state_t;

   state_t     state;
   logic       legal;
   logic [2:0] imm_sel;
   logic       pc_write_c, adr_src_c, ir_write_c, mem_write_c, reg_write_c, done_c;

   function automatic logic [2:0] alu_r(input logic [6:0] f7, input logic [2:0] f3);
      case ({f7, f3})
         {7'h00, 3'b000}: return ALU_ADD;
         {7'h20, 3'b000}: return ALU_SUB;
         {7'h00, 3'b111}: return ALU_AND;
         {7'h00, 3'b110}: return ALU_OR;
         {7'h00, 3'b010}: return ALU_SLT;
         default:         return ALU_ADD;
      endcase
   endfunction

   function automatic logic [2:0] alu_i(input logic [2:0] f3);
      case (f3)
         3'b110:  return ALU_OR;
         3'b010:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   assign legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LW) ||
                  (opcode == OP_SW) || (opcode == OP_BR) || (opcode == OP_JAL) ||
                  (opcode == OP_JALR) || (opcode == OP_LUI);

   always_comb begin
      case (opcode)
         OP_SW:   imm_sel = 3'b001;
         OP_BR:   imm_sel = 3'b010;
         OP_JAL:  imm_sel = 3'b011;
         OP_LUI:  imm_sel = 3'b100;
         default: imm_sel = 3'b000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:   if (mem_ready) state <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_R:         state <= S_EXEC_R;
                  OP_I:         state <= S_EXEC_I;
                  OP_LW, OP_SW: state <= S_MEM_ADR;
                  OP_BR:        state <= S_BRANCH;
                  OP_JAL:       state <= S_JAL;
                  OP_JALR:      state <= S_JALR;
                  OP_LUI:       state <= S_LUI;
                  default:      state <= HALT_ON_ILLEGAL ? S_ERROR : S_FETCH;
               endcase
            end
            S_EXEC_R, S_EXEC_I, S_JAL, S_JALR_PC: state <= S_ALU_WB;
            S_MEM_ADR: state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (mem_ready) state <= S_MEM_WB;
            S_MEM_WR:  if (mem_ready) state <= S_FETCH;
            S_JALR:    state <= S_JALR_PC;
            S_ERROR:   state <= S_ERROR;
            default:   state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      pc_write_c  = 1'b0;
      adr_src_c   = 1'b0;
      ir_write_c  = 1'b0;
      mem_write_c = 1'b0;
      reg_write_c = 1'b0;
      done_c      = 1'b0;
      ResultSrc   = 2'b00;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ALUControl  = ALU_ADD;
      case (state)
         S_FETCH: begin
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            ir_write_c = mem_ready;
            pc_write_c = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            done_c  = !legal && !HALT_ON_ILLEGAL;
         end
         S_EXEC_R: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_r(func7, func3);
         end
         S_EXEC_I: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_i(func3);
         end
         S_ALU_WB, S_MEM_WB: begin
            ResultSrc   = (state == S_MEM_WB) ? 2'b01 : 2'b00;
            reg_write_c = 1'b1;
            done_c      = 1'b1;
         end
         S_MEM_ADR, S_JALR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEM_RD: adr_src_c = 1'b1;
         S_MEM_WR: begin
            adr_src_c   = 1'b1;
            mem_write_c = 1'b1;
            done_c      = mem_ready;
         end
         S_BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            pc_write_c = ((func3 == 3'b000) && zero) || ((func3 == 3'b001) && !zero);
            done_c     = 1'b1;
         end
         // PC takes the target held in ALUOut while the ALU forms OldPC+4 for the link
         S_JAL, S_JALR_PC: begin
            pc_write_c = 1'b1;
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
         end
         S_LUI: begin
            ResultSrc   = 2'b11;
            reg_write_c = 1'b1;
            done_c      = 1'b1;
         end
         default: ;
      endcase
   end

   // FETCH strobes follow mem_ready, so rst must mask them while the reset is held
   assign PCWrite    = pc_write_c & ~rst;
   assign AdrSrc     = adr_src_c;
   assign IRWrite    = ir_write_c & ~rst;
   assign MemWrite   = mem_write_c & ~rst;
   assign RegWrite   = reg_write_c & ~rst;
   assign instr_done = done_c & ~rst;
   assign illegal    = (state == S_ERROR) & ~rst;
   assign ImmSrc     = (state == S_FETCH) ? 3'b000 : imm_sel;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction expected output sequences
// built from the instruction-level behaviour, checked every cycle, plus literal latency checks.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic [2:0] func3 = 3'd0;
   logic [6:0] func7 = 7'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, instr_done, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ALUControl, ImmSrc;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_lat = 0;
   int rw_cnt = 0;
   logic [18:0] expq[$];

   multicycle_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instr_done(instr_done),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Expected output vector {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,SrcA,SrcB,ALU,Imm,done,illegal}
   function automatic logic [18:0] mk(input int pcw, adr, irw, mw, rw, rs, sa, sb, alu, imm, done, ill);
      logic [18:0] v;
      v = {pcw[0], adr[0], irw[0], mw[0], rw[0], rs[1:0], sa[1:0], sb[1:0], alu[2:0], imm[2:0],
           done[0], ill[0]};
      return v;
   endfunction

   function automatic int imm_of(input logic [6:0] op);
      case (op)
         7'd35:   return 1;
         7'd99:   return 2;
         7'd111:  return 3;
         7'd55:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic int alu_r_of(input logic [6:0] f7, input logic [2:0] f3);
      if (f7 == 7'h20 && f3 == 3'd0) return 1;
      if (f7 != 7'h00) return 0;
      case (f3)
         3'd7:    return 2;
         3'd6:    return 3;
         3'd2:    return 5;
         default: return 0;
      endcase
   endfunction

   function automatic int alu_i_of(input logic [2:0] f3);
      case (f3)
         3'd6:    return 3;
         3'd2:    return 5;
         default: return 0;
      endcase
   endfunction

   task automatic step(input logic r, input logic mr, input logic z, input logic [18:0] e);
      @(negedge clk);
      #1;
      rst = r;
      mem_ready = mr;
      zero = z;
      expq.push_back(e);
      #3;
   endtask

   // Compare process: every driven cycle, outputs must equal the expected vector
   initial begin
      logic [18:0] e, act;
      forever begin
         @(negedge clk);
         #2;
         while (expq.size() > 0) begin
            e = expq.pop_front();
            act = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUControl, ImmSrc, instr_done, illegal};
            chk($sformatf("outputs@%0t", $time), 32'(act), 32'(e));
         end
      end
   end

   // Instruction latency and register-write counting, taken from the DUT's own strobes
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (rst) cyc = 0;
         else begin
            cyc++;
            if (RegWrite) rw_cnt++;
            if (instr_done) begin
               last_lat = cyc;
               cyc = 0;
            end
         end
      end
   end

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic z, input int wf, input int wm, input int exp_lat,
                            input int exp_rw, input string nm);
      int im;
      logic [18:0] wb;
      opcode = op;
      func3 = f3;
      func7 = f7;
      rw_cnt = 0;
      im = imm_of(op);
      wb = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, im, 1, 0);
      for (int i = 0; i < wf; i++) step(1'b0, 1'b0, z, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
      step(1'b0, 1'b1, z, mk(1, 0, 1, 0, 0, 2, 0, 2, 0, 0, 0, 0));
      step(1'b0, 1'b1, z, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, im, 0, 0));
      case (op)
         7'd51: begin
            step(1'b0, 1'b1, z, mk(0, 0, 0, 0, 0, 0, 2, 0, alu_r_of(f7, f3), im, 0, 0));
            step(1'b0, 1'b1, z, wb);
         end
         7'd19: begin
            step(1'b0, 1'b1, z, mk(0, 0, 0, 0, 0, 0, 2, 1, alu_i_of(f3), im, 0, 0));
            step(1'b0, 1'b1, z, wb);
         end
         7'd3: begin
            step(1'b0, 1'b1, z, mk(0, 0, 0, 0, 0, 0, 2, 1, 0, im, 0, 0));
            for (int i = 0; i < wm; i++) step(1'b0, 1'b0, z, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, im, 0, 0));
            step(1'b0, 1'b1, z, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, im, 0, 0));
            step(1'b0, 1'b1, z, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, im, 1, 0));
         end
         7'd35: begin
            step(1'b0, 1'b1, z, mk(0, 0, 0, 0, 0, 0, 2, 1, 0, im, 0, 0));
            for (int i = 0; i < wm; i++) step(1'b0, 1'b0, z, mk(0, 1, 0, 1, 0, 0, 0, 0, 0, im, 0, 0));
            step(1'b0, 1'b1, z, mk(0, 1, 0, 1, 0, 0, 0, 0, 0, im, 1, 0));
         end
         7'd99: begin
            int taken;
            taken = ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z)) ? 1 : 0;
            step(1'b0, 1'b1, z, mk(taken, 0, 0, 0, 0, 0, 2, 0, 1, im, 1, 0));
         end
         7'd111: begin
            step(1'b0, 1'b1, z, mk(1, 0, 0, 0, 0, 0, 1, 2, 0, im, 0, 0));
            step(1'b0, 1'b1, z, wb);
         end
         7'd103: begin
            step(1'b0, 1'b1, z, mk(0, 0, 0, 0, 0, 0, 2, 1, 0, im, 0, 0));
            step(1'b0, 1'b1, z, mk(1, 0, 0, 0, 0, 0, 1, 2, 0, im, 0, 0));
            step(1'b0, 1'b1, z, wb);
         end
         7'd55: step(1'b0, 1'b1, z, mk(0, 0, 0, 0, 1, 3, 0, 0, 0, im, 1, 0));
         default: ;
      endcase
      chk({nm, "_latency"}, 32'(last_lat), 32'(exp_lat));
      chk({nm, "_regwrites"}, 32'(rw_cnt), 32'(exp_rw));
   endtask

   initial begin
      // reset held: strobes masked even with mem_ready high
      step(1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
      chk("reset_illegal", 32'(illegal), 32'd0);

      run_instr(7'd51, 3'd0, 7'h00, 1'b0, 0, 0, 4, 1, "add");
      run_instr(7'd51, 3'd0, 7'h20, 1'b0, 0, 0, 4, 1, "sub");
      run_instr(7'd51, 3'd7, 7'h00, 1'b0, 0, 0, 4, 1, "and");
      run_instr(7'd51, 3'd6, 7'h00, 1'b0, 0, 0, 4, 1, "or");
      run_instr(7'd51, 3'd2, 7'h00, 1'b0, 0, 0, 4, 1, "slt");
      run_instr(7'd51, 3'd7, 7'h20, 1'b0, 0, 0, 4, 1, "r_other");
      run_instr(7'd51, 3'd0, 7'h00, 1'b0, 2, 0, 6, 1, "add_fetchwait");
      run_instr(7'd19, 3'd0, 7'h00, 1'b0, 0, 0, 4, 1, "addi");
      run_instr(7'd19, 3'd6, 7'h00, 1'b0, 0, 0, 4, 1, "ori");
      run_instr(7'd19, 3'd2, 7'h00, 1'b0, 0, 0, 4, 1, "slti");
      run_instr(7'd19, 3'd4, 7'h00, 1'b0, 0, 0, 4, 1, "i_other");
      run_instr(7'd3,  3'd2, 7'h00, 1'b0, 0, 2, 7, 1, "lw_wait2");
      run_instr(7'd3,  3'd2, 7'h00, 1'b0, 0, 0, 5, 1, "lw");
      run_instr(7'd35, 3'd2, 7'h00, 1'b0, 0, 0, 4, 0, "sw");
      run_instr(7'd35, 3'd2, 7'h00, 1'b0, 0, 2, 6, 0, "sw_wait2");
      run_instr(7'd99, 3'd0, 7'h00, 1'b1, 0, 0, 3, 0, "beq_taken");
      run_instr(7'd99, 3'd0, 7'h00, 1'b0, 0, 0, 3, 0, "beq_not");
      run_instr(7'd99, 3'd1, 7'h00, 1'b1, 0, 0, 3, 0, "bne_not");
      run_instr(7'd99, 3'd1, 7'h00, 1'b0, 0, 0, 3, 0, "bne_taken");
      run_instr(7'd99, 3'd4, 7'h00, 1'b1, 0, 0, 3, 0, "br_f3_other");
      run_instr(7'd111, 3'd0, 7'h00, 1'b0, 0, 0, 4, 1, "jal");
      run_instr(7'd103, 3'd0, 7'h00, 1'b0, 0, 0, 5, 1, "jalr");
      run_instr(7'd55, 3'd0, 7'h00, 1'b0, 0, 0, 3, 1, "lui");

      // reset during a stalled store: MemWrite must drop in the same cycle
      opcode = 7'd35;
      func3 = 3'd2;
      func7 = 7'h00;
      step(1'b0, 1'b1, 1'b0, mk(1, 0, 1, 0, 0, 2, 0, 2, 0, 0, 0, 0));
      step(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
      step(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0));
      step(1'b0, 1'b0, 1'b0, mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      step(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
      chk("sw_abort_memwrite", 32'(MemWrite), 32'd0);
      run_instr(7'd51, 3'd0, 7'h00, 1'b0, 0, 0, 4, 1, "add_after_abort");

      // illegal opcode parks in ERROR until reset
      opcode = 7'h7F;
      func3 = 3'd0;
      step(1'b0, 1'b1, 1'b0, mk(1, 0, 1, 0, 0, 2, 0, 2, 0, 0, 0, 0));
      step(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      chk("illegal_held", 32'(illegal), 32'd1);
      step(1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
      chk("illegal_cleared", 32'(illegal), 32'd0);
      run_instr(7'd51, 3'd0, 7'h00, 1'b0, 0, 0, 4, 1, "add_after_error");

      @(negedge clk);
      #3;
      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
      $fatal(1, "timeout");
   end

endmodule
